// File: rtl/secuenciador_motores.sv
// secuenciador_motores: runs the R, G and B dispensing motors one at a time with an idle gap between channels
module secuenciador_motores #(
   parameter int WIDTH           = 5,
   parameter int TICKS_PER_CYCLE = 4,
   parameter int GAP_TICKS       = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] ciclos_R,
   input  logic [WIDTH-1:0] ciclos_G,
   input  logic [WIDTH-1:0] ciclos_B,
   output logic [2:0]       Motores,
   output logic [1:0]       canal,
   output logic [WIDTH-1:0] restante,
   output logic             busy,
   output logic             done,
   output logic             aborted
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, FIN} state_t;
   localparam int TMAX = TICKS_PER_CYCLE > GAP_TICKS ? TICKS_PER_CYCLE : GAP_TICKS;
   localparam int CW   = $clog2(TMAX + 1);
   state_t           state, state_n;
   logic [WIDTH-1:0] lat_r, lat_g, lat_b, lat_r_n, lat_g_n, lat_b_n;
   logic [CW-1:0]    tcnt, tcnt_n;
   logic [2:0]       motores_n, mot_sel;
   logic [1:0]       canal_n, nxt;
   logic [WIDTH-1:0] restante_n, nxt_cnt;
   logic             done_n, aborted_n;
   // next nonzero channel strictly after the current one (canal is 0 in LOAD)
   always_comb begin
      nxt     = (canal < 2'd1 && lat_r != '0) ? 2'd1 :
                (canal < 2'd2 && lat_g != '0) ? 2'd2 :
                (canal < 2'd3 && lat_b != '0) ? 2'd3 : 2'd0;
      nxt_cnt = nxt == 2'd1 ? lat_r : nxt == 2'd2 ? lat_g : lat_b;
      mot_sel = nxt == 2'd1 ? 3'b100 : nxt == 2'd2 ? 3'b010 : nxt == 2'd3 ? 3'b001 : 3'b000;
   end
   always_comb begin
      state_n    = state;
      lat_r_n    = lat_r;
      lat_g_n    = lat_g;
      lat_b_n    = lat_b;
      tcnt_n     = tcnt;
      motores_n  = Motores;
      canal_n    = canal;
      restante_n = restante;
      done_n     = 1'b0;
      aborted_n  = 1'b0;
      if (state != IDLE && abort) begin
         state_n    = IDLE;
         lat_r_n    = '0;
         lat_g_n    = '0;
         lat_b_n    = '0;
         tcnt_n     = '0;
         motores_n  = '0;
         canal_n    = '0;
         restante_n = '0;
         aborted_n  = 1'b1;
      end else begin
         case (state)
            IDLE: if (start && !abort) begin
               lat_r_n = ciclos_R;
               lat_g_n = ciclos_G;
               lat_b_n = ciclos_B;
               state_n = LOAD;
            end
            LOAD, GAP: if (state == LOAD || (tick && tcnt == CW'(GAP_TICKS - 1))) begin
               tcnt_n = '0;
               if (nxt != 2'd0) begin
                  state_n    = RUN;
                  motores_n  = mot_sel;
                  canal_n    = nxt;
                  restante_n = nxt_cnt;
               end else begin
                  state_n    = FIN;
                  canal_n    = '0;
                  restante_n = '0;
                  done_n     = 1'b1;
               end
            end else if (tick) tcnt_n = tcnt + 1'b1;
            RUN: if (tick) begin
               if (tcnt == CW'(TICKS_PER_CYCLE - 1)) begin
                  tcnt_n = '0;
                  if (restante != '0) restante_n = restante - 1'b1;
                  if (restante <= WIDTH'(1)) begin
                     motores_n = '0;
                     state_n   = nxt != 2'd0 ? GAP : FIN;
                     if (nxt == 2'd0) begin
                        canal_n    = '0;
                        restante_n = '0;
                        done_n     = 1'b1;
                     end
                  end
               end else tcnt_n = tcnt + 1'b1;
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         lat_r    <= '0;
         lat_g    <= '0;
         lat_b    <= '0;
         tcnt     <= '0;
         Motores  <= '0;
         canal    <= '0;
         restante <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state    <= state_n;
         lat_r    <= lat_r_n;
         lat_g    <= lat_g_n;
         lat_b    <= lat_b_n;
         tcnt     <= tcnt_n;
         Motores  <= motores_n;
         canal    <= canal_n;
         restante <= restante_n;
         busy     <= state_n != IDLE;
         done     <= done_n;
         aborted  <= aborted_n;
      end
   end
endmodule

// File: tb/tb_secuenciador_motores.sv
// tb_secuenciador_motores: directed checks of channel sequencing, gaps, skipping, abort and reset
module tb_secuenciador_motores;
   logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, abort = 1'b0;
   logic [4:0] ciclos_R = '0, ciclos_G = '0, ciclos_B = '0;
   logic [2:0] Motores;
   logic [1:0] canal;
   logic [4:0] restante;
   logic       busy, done, aborted;
   int         nt = 0, nf = 0, done_cnt = 0, ab_cnt = 0;
   secuenciador_motores dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
      .ciclos_R(ciclos_R), .ciclos_G(ciclos_G), .ciclos_B(ciclos_B),
      .Motores(Motores), .canal(canal), .restante(restante),
      .busy(busy), .done(done), .aborted(aborted)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      nt++;
      assert ($countones(Motores) <= 1) else begin
         nf++;
         $error("FAIL onehot: observed %b expected at most one bit", Motores);
      end
      if (done) done_cnt++;
      if (aborted) ab_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nt++;
      assert (obs === exp) else begin
         nf++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run_ticks(input int n);
      repeat (n) begin
         repeat (9) step();
         tick = 1'b1;
         step();
         tick = 1'b0;
      end
   endtask
   task automatic chk_out(input string tag, input logic [2:0] m, input logic [1:0] c,
                          input logic [4:0] r, input logic b, input logic d, input logic a);
      chk({tag, ".Motores"}, 32'(Motores), 32'(m));
      chk({tag, ".canal"}, 32'(canal), 32'(c));
      chk({tag, ".restante"}, 32'(restante), 32'(r));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".done"}, 32'(done), 32'(d));
      chk({tag, ".aborted"}, 32'(aborted), 32'(a));
   endtask
   initial begin
      #2;
      chk_out("reset", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      step();
      // R=2, G=0, B=1: G skipped, one gap between R and B
      ciclos_R = 5'd2; ciclos_G = 5'd0; ciclos_B = 5'd1;
      done_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("t1.load", 3'b000, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk_out("t1.run_r", 3'b100, 2'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      run_ticks(4);
      chk_out("t1.r_half", 3'b100, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(4);
      chk_out("t1.gap", 3'b000, 2'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      run_ticks(1);
      chk_out("t1.gap2", 3'b000, 2'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      run_ticks(1);
      chk_out("t1.run_b", 3'b001, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(3);
      chk_out("t1.b_late", 3'b001, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(1);
      chk_out("t1.fin", 3'b000, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      chk_out("t1.idle", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t1.done_cnt", 32'(done_cnt), 32'd1);
      // all counts zero: LOAD then FIN, no motor
      ciclos_R = 5'd0; ciclos_G = 5'd0; ciclos_B = 5'd0;
      done_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("t2.load", 3'b000, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk_out("t2.fin", 3'b000, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      chk_out("t2.idle", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t2.done_cnt", 32'(done_cnt), 32'd1);
      // abort mid-G, then a clean R=1 run
      ciclos_R = 5'd3; ciclos_G = 5'd3; ciclos_B = 5'd3;
      done_cnt = 0; ab_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk_out("t3.run_r", 3'b100, 2'd1, 5'd3, 1'b1, 1'b0, 1'b0);
      run_ticks(12);
      chk_out("t3.gap", 3'b000, 2'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      run_ticks(2);
      chk_out("t3.run_g", 3'b010, 2'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      run_ticks(5);
      chk_out("t3.g_mid", 3'b010, 2'd2, 5'd2, 1'b1, 1'b0, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_out("t3.abort", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      step();
      chk_out("t3.after", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t3.done_cnt", 32'(done_cnt), 32'd0);
      chk("t3.ab_cnt", 32'(ab_cnt), 32'd1);
      ciclos_R = 5'd1; ciclos_G = 5'd0; ciclos_B = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk_out("t3.rerun", 3'b100, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(3);
      chk_out("t3.rerun3", 3'b100, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(1);
      chk_out("t3.fin", 3'b000, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      // start and abort together in IDLE
      done_cnt = 0; ab_cnt = 0;
      start = 1'b1; abort = 1'b1;
      step();
      chk_out("t4.s_a", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      start = 1'b0; abort = 1'b0;
      step();
      chk_out("t4.after", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t4.pulses", 32'(done_cnt + ab_cnt), 32'd0);
      // count change and re-start while busy are ignored
      ciclos_R = 5'd1; ciclos_G = 5'd0; ciclos_B = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      ciclos_B = 5'd5;
      start = 1'b1;
      run_ticks(2);
      start = 1'b0;
      chk_out("t5.run_r", 3'b100, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      run_ticks(2);
      chk_out("t5.fin", 3'b000, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      chk_out("t5.idle", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      // async reset between edges mid-RUN
      ciclos_R = 5'd3; ciclos_B = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      run_ticks(1);
      chk_out("t6.run", 3'b100, 2'd1, 5'd3, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_out("t6.async", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      step();
      chk_out("t6.idle", 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end
endmodule
